// File: rtl/n2t_rom_loader_if.sv
// ROM write port driven by the UART bootloader: one-cycle strobe,
// word address and 16-bit instruction word.
interface n2t_rom_loader_if #(
   parameter int ADDR_W = 15
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_data;

   modport master (output wr_en, wr_addr, wr_data);
   modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/n2t_rom_loader.sv
// UART bootloader for the Hack instruction ROM: receives A5/count/words frames,
// writes the ROM and holds the CPU in reset until a full image has landed.
// Optional trailing checksum byte is compiled in with N2T_LOADER_CHECKSUM_EN.
module n2t_rom_loader #(
   parameter int CLK_HZ      = 12000000,
   parameter int BAUD        = 115200,
   parameter int ADDR_W      = 15,
   parameter int TIMEOUT_CYC = 1200000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               uart_rx,
   n2t_rom_loader_if.master   rom,
   output logic               cpu_reset,
   output logic               done,
   output logic               err
);

   localparam int CPB       = CLK_HZ / BAUD;
   localparam int BW        = $clog2(CPB + 1);
   localparam int TW        = $clog2(TIMEOUT_CYC + 1);
   localparam logic [BW-1:0] CPB_M1  = BW'(CPB - 1);
   localparam logic [BW-1:0] HALF_M1 = BW'(CPB / 2 - 1);
   localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT_CYC - 1);
   localparam int unsigned   MAX_WORDS = 32'd1 << ADDR_W;
   localparam logic [7:0]    MAGIC   = 8'hA5;

   // ---------------------------------------------------------------- RX
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t       rx_state;
   logic [1:0]      rx_sync;
   logic            rx_prev;
   logic [BW-1:0]   baud_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      rx_byte;
   logic            rx_valid;
   logic            rx_ferr;

   wire rx_s = rx_sync[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: synchronizer resets to the idle-high line level so no false start edge appears
         rx_sync  <= 2'b11;
         rx_prev  <= 1'b1;
         rx_state <= RX_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         rx_byte  <= '0;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         // NOTE: non-blocking everywhere here so every flop samples pre-edge values
         rx_sync  <= {rx_sync[0], uart_rx};
         rx_prev  <= rx_s;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               baud_cnt <= '0;
               if (rx_prev && !rx_s) rx_state <= RX_START;
            end
            RX_START: begin
               if (baud_cnt == HALF_M1) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  rx_state <= rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (baud_cnt == CPB_M1) begin
                  baud_cnt <= '0;
                  rx_byte  <= {rx_s, rx_byte[7:1]};
                  if (bit_idx == 3'd7) rx_state <= RX_STOP;
                  else                 bit_idx  <= bit_idx + 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (baud_cnt == CPB_M1) begin
                  baud_cnt <= '0;
                  rx_state <= RX_IDLE;
                  if (rx_s) rx_valid <= 1'b1;
                  else      rx_ferr  <= 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- loader
`ifdef N2T_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {SYNC, CNT_HI, CNT_LO, DAT_HI, DAT_LO, CHK, DONE} state_t;
   localparam state_t END_STATE = CHK;
`else
   typedef enum logic [2:0] {SYNC, CNT_HI, CNT_LO, DAT_HI, DAT_LO, DONE} state_t;
   localparam state_t END_STATE = DONE;
`endif

   state_t        state;
   logic [7:0]    count_hi;
   logic [7:0]    hi_byte;
   logic [15:0]   words_left;
   logic [TW-1:0] to_cnt;
   logic [15:0]   count_next;
   logic          in_frame;

   assign count_next = {count_hi, rx_byte};
   assign in_frame   = (state != SYNC) && (state != DONE);

`ifdef N2T_LOADER_CHECKSUM_EN
   logic [7:0] csum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           csum <= '0;
      else if (rx_valid) csum <= (state == CNT_HI) ? rx_byte : csum + rx_byte;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= SYNC;
         rom.wr_en   <= 1'b0;
         rom.wr_addr <= '0;
         rom.wr_data <= '0;
         cpu_reset   <= 1'b1;
         done        <= 1'b0;
         err         <= 1'b0;
         count_hi    <= '0;
         hi_byte     <= '0;
         words_left  <= '0;
         to_cnt      <= '0;
      end else begin
         rom.wr_en <= 1'b0;
         // Address advances the cycle after each write strobe.
         if (rom.wr_en) rom.wr_addr <= rom.wr_addr + 1'b1;

         if (!in_frame || rx_valid) to_cnt <= '0;
         else                       to_cnt <= to_cnt + 1'b1;

         // DONE drives the release; a later magic byte in this cycle overrides it.
         if (state == DONE) begin
            cpu_reset <= 1'b0;
            done      <= 1'b1;
         end

         if (rx_ferr && state != DONE) begin
            err   <= 1'b1;
            state <= SYNC;
         end else if (in_frame && !rx_valid && to_cnt == TO_M1) begin
            err   <= 1'b1;
            state <= SYNC;
         end else if (rx_valid) begin
            case (state)
               SYNC, DONE: begin
                  if (rx_byte == MAGIC) begin
                     state       <= CNT_HI;
                     cpu_reset   <= 1'b1;
                     done        <= 1'b0;
                     err         <= 1'b0;
                     rom.wr_addr <= '0;
                  end
               end
               CNT_HI: begin
                  count_hi <= rx_byte;
                  state    <= CNT_LO;
               end
               CNT_LO: begin
                  words_left <= count_next;
                  if (count_next == 16'd0) begin
                     state <= END_STATE;
                  end else if (32'(count_next) > MAX_WORDS) begin
                     err   <= 1'b1;
                     state <= SYNC;
                  end else begin
                     state <= DAT_HI;
                  end
               end
               DAT_HI: begin
                  hi_byte <= rx_byte;
                  state   <= DAT_LO;
               end
               DAT_LO: begin
                  rom.wr_data <= {hi_byte, rx_byte};
                  rom.wr_en   <= 1'b1;
                  words_left  <= words_left - 1'b1;
                  state       <= (words_left == 16'd1) ? END_STATE : DAT_HI;
               end
`ifdef N2T_LOADER_CHECKSUM_EN
               CHK: begin
                  if (rx_byte == csum) begin
                     state <= DONE;
                  end else begin
                     err   <= 1'b1;
                     state <= SYNC;
                  end
               end
`endif
               default: state <= SYNC;
            endcase
         end
      end
   end

endmodule
